// File: rtl/selfdestruct_sequencer.sv
// ---------------------------------------------------------------------------
// selfdestruct_sequencer
//
// Purpose:
//   Control FSM for the self-destruct countdown. A threat is at least two of
//   {danger, damaged, immobilized}. The threat must hold for ARM_TICKS ticks
//   before the countdown starts. The countdown fills an 8-LED bar one step
//   every STEP_TICKS ticks. A blink phase of FINAL_TICKS ticks follows, and
//   then the block latches a sticky detonate state. Abort or loss of combat
//   before detonation sends the FSM to a cooldown state. The FSM returns to
//   idle after COOLDOWN_TICKS ticks.
//
//   All decisions are made on prescaler ticks (one every CLK_DIV clocks).
//   Between ticks every output holds.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   in_combat    in   debounced combat level
//   danger       in   debounced threat input
//   damaged      in   debounced threat input
//   immobilized  in   debounced threat input
//   abort        in   debounced abort request (level)
//   leds[7:0]    out  LED pattern (registered)
//   state[2:0]   out  FSM state: IDLE=0 ARMED=1 COUNTDOWN=2 FINAL=3
//                     DETONATE=4 ABORTED=5 (registered)
//   detonate     out  high only in DETONATE (registered)
// ---------------------------------------------------------------------------
module selfdestruct_sequencer #(
    parameter int unsigned CLK_DIV        = 120000,
    parameter int unsigned ARM_TICKS      = 100,
    parameter int unsigned STEP_TICKS     = 125,
    parameter int unsigned BLINK_TICKS    = 33,
    parameter int unsigned FINAL_TICKS    = 300,
    parameter int unsigned COOLDOWN_TICKS = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_combat,
    input  logic       danger,
    input  logic       damaged,
    input  logic       immobilized,
    input  logic       abort,
    output logic [7:0] leds,
    output logic [2:0] state,
    output logic       detonate
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARMED     = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_FINAL     = 3'd3,
        S_DETONATE  = 3'd4,
        S_ABORTED   = 3'd5
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_TICKS =
        max_u(max_u(max_u(ARM_TICKS, STEP_TICKS), max_u(BLINK_TICKS, FINAL_TICKS)),
              COOLDOWN_TICKS);

    // The tick counters never wrap inside a state, so they must hold the
    // largest tick parameter. They are never narrower than 16 bits.
    localparam int unsigned TCNT_W = ($clog2(MAX_TICKS + 1) > 16) ? $clog2(MAX_TICKS + 1) : 16;
    localparam int unsigned PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Each timer compares against (N-1). A timer reaches that value on the
    // N-th tick after entry, because the counter reads 0 on the entry tick.
    // With N=1 the exit therefore happens on the very next tick.
    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_DIV - 1);
    localparam logic [TCNT_W-1:0] ARM_LAST   = TCNT_W'(ARM_TICKS - 1);
    localparam logic [TCNT_W-1:0] STEP_LAST  = TCNT_W'(STEP_TICKS - 1);
    localparam logic [TCNT_W-1:0] BLINK_LAST = TCNT_W'(BLINK_TICKS - 1);
    localparam logic [TCNT_W-1:0] FINAL_LAST = TCNT_W'(FINAL_TICKS - 1);
    localparam logic [TCNT_W-1:0] COOL_LAST  = TCNT_W'(COOLDOWN_TICKS - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE   = TCNT_W'(1);
    localparam logic [PRE_W-1:0]  PRE_ONE    = PRE_W'(1);

    state_t              state_q,  state_d;
    logic [PRE_W-1:0]    pre_q,    pre_d;
    logic [TCNT_W-1:0]   tcnt_q,   tcnt_d;
    logic [TCNT_W-1:0]   bcnt_q,   bcnt_d;
    logic [7:0]          bar_q,    bar_d;
    logic [7:0]          leds_q,   leds_d;
    logic                det_q,    det_d;

    logic tick;
    logic threat;
    logic ok;

    // Qualified conditions. 2-of-3 majority for the threat. The mission is
    // "ok" while in combat with no abort request.
    assign threat = (danger & damaged) | (danger & immobilized) | (damaged & immobilized);
    assign ok     = in_combat & ~abort;

    // Free-running prescaler. The tick is high for the one cycle at the top
    // of the count, so the FSM advances on the edge that ends that cycle.
    assign tick  = (pre_q == PRE_LAST);
    always_comb begin
        pre_d = tick ? '0 : pre_q + PRE_ONE;
    end

    // Next-state logic. Each state handles its exits in the same order:
    // abort/combat loss first, then threat loss, then timer expiry. Every
    // state change clears tcnt and bcnt. The bar is cleared on any exit
    // from COUNTDOWN. Outputs are computed here for the next state so the
    // registered outputs line up with the registered state.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        bar_d   = bar_q;
        leds_d  = leds_q;
        det_d   = det_q;

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (threat && ok) begin
                        state_d = S_ARMED;
                        tcnt_d  = '0;
                        leds_d  = 8'h00;
                    end
                end

                S_ARMED: begin
                    if (!ok) begin
                        state_d = S_ABORTED;
                        tcnt_d  = '0;
                        leds_d  = 8'h00;
                    end else if (!threat) begin
                        state_d = S_IDLE;
                        tcnt_d  = '0;
                        leds_d  = 8'h00;
                    end else if (tcnt_q == ARM_LAST) begin
                        state_d = S_COUNTDOWN;
                        tcnt_d  = '0;
                        bar_d   = 8'h01;
                        leds_d  = 8'h01;
                    end else begin
                        tcnt_d  = tcnt_q + TCNT_ONE;
                    end
                end

                // Threat is deliberately ignored here. Once the bar starts
                // filling, only abort or loss of combat can stop it.
                S_COUNTDOWN: begin
                    if (!ok) begin
                        state_d = S_ABORTED;
                        tcnt_d  = '0;
                        bar_d   = 8'h00;
                        leds_d  = 8'h00;
                    end else if (tcnt_q == STEP_LAST) begin
                        tcnt_d = '0;
                        if (bar_q == 8'hFF) begin
                            state_d = S_FINAL;
                            bcnt_d  = '0;
                            bar_d   = 8'h00;
                            leds_d  = 8'h00;
                        end else begin
                            bar_d  = {bar_q[6:0], 1'b1};
                            leds_d = {bar_q[6:0], 1'b1};
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_ONE;
                    end
                end

                // tcnt times the whole phase and bcnt times each blink. The
                // exit check comes first, so a blink that falls on the exit
                // tick never shows.
                S_FINAL: begin
                    if (!ok) begin
                        state_d = S_ABORTED;
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        leds_d  = 8'h00;
                    end else if (tcnt_q == FINAL_LAST) begin
                        state_d = S_DETONATE;
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        leds_d  = 8'hFF;
                        det_d   = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_ONE;
                        if (bcnt_q == BLINK_LAST) begin
                            bcnt_d = '0;
                            leds_d = ~leds_q;
                        end else begin
                            bcnt_d = bcnt_q + TCNT_ONE;
                        end
                    end
                end

                // Terminal state. Only reset leaves it.
                S_DETONATE: begin
                    leds_d = 8'hFF;
                    det_d  = 1'b1;
                end

                // The cooldown runs its full length regardless of inputs.
                // IDLE then re-arms only once abort has dropped.
                S_ABORTED: begin
                    if (tcnt_q == COOL_LAST) begin
                        state_d = S_IDLE;
                        tcnt_d  = '0;
                        leds_d  = 8'h00;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_ONE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                    bar_d   = 8'h00;
                    leds_d  = 8'h00;
                    det_d   = 1'b0;
                end
            endcase
        end
    end

    // Single state register for the FSM, its counters and its registered
    // outputs. A synchronous reset overrides everything, including a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            bar_q   <= 8'h00;
            leds_q  <= 8'h00;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            bar_q   <= bar_d;
            leds_q  <= leds_d;
            det_q   <= det_d;
        end
    end

    assign leds     = leds_q;
    assign state    = state_q;
    assign detonate = det_q;

endmodule

// File: tb/tb_selfdestruct_sequencer.sv
// ---------------------------------------------------------------------------
// tb_selfdestruct_sequencer
//
// Directed scenarios for selfdestruct_sequencer with short timers. Expected
// (state, leds, detonate) triples are hand-computed and queued against an
// absolute cycle count since the last reset. A separate monitor pops and
// compares each entry when its cycle arrives. Tick k lands at cycle 4k.
// ---------------------------------------------------------------------------
module tb_selfdestruct_sequencer;

    localparam int CLK_DIV = 4;
    localparam int TIMEOUT = 4000;

    localparam logic [2:0] IDLE = 3'd0, ARMED = 3'd1, CDOWN = 3'd2,
                           FINAL = 3'd3, DET = 3'd4, ABRT = 3'd5;

    logic       clk;
    logic       reset;
    logic       in_combat, danger, damaged, immobilized, abort;
    logic [7:0] leds;
    logic [2:0] state;
    logic       detonate;

    typedef struct {
        int         ep;
        int         cyc;
        logic [2:0] st;
        logic [7:0] leds;
        logic       det;
        string      nm;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    int ep      = 0;

    logic [7:0] barTab [7];

    selfdestruct_sequencer #(
        .CLK_DIV(4), .ARM_TICKS(3), .STEP_TICKS(2),
        .BLINK_TICKS(1), .FINAL_TICKS(4), .COOLDOWN_TICKS(5)
    ) dut (
        .clk(clk), .reset(reset), .in_combat(in_combat), .danger(danger),
        .damaged(damaged), .immobilized(immobilized), .abort(abort),
        .leds(leds), .state(state), .detonate(detonate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count since the posedge that sampled reset. Each reset opens a
    // new epoch so stale expectations are never matched across resets.
    always @(posedge clk) begin
        if (reset) begin
            cyc <= 0;
            ep  <= ep + 1;
        end else begin
            cyc <= cyc + 1;
        end
    end

    // Monitor: every cycle, just after the edge, compare all queued entries
    // that are due by now.
    always begin
        @(posedge clk);
        #1;
        while (expQ.size() > 0 &&
               (expQ[0].ep < ep || (expQ[0].ep == ep && expQ[0].cyc <= cyc))) begin
            cur = expQ.pop_front();
            vectors++;
            if (cur.ep != ep || cur.cyc != cyc) begin
                fails++;
                $display("[TB] FAIL %s: not sampled, now ep%0d cyc%0d, required ep%0d cyc%0d",
                         cur.nm, ep, cyc, cur.ep, cur.cyc);
            end else if (state !== cur.st || leds !== cur.leds || detonate !== cur.det) begin
                fails++;
                $display("[TB] FAIL %s @cyc%0d: got state=%0d leds=%02h det=%b, required state=%0d leds=%02h det=%b",
                         cur.nm, cyc, state, leds, detonate, cur.st, cur.leds, cur.det);
            end
        end
    end

    task automatic checkAt(input int e, input int c, input logic [2:0] s,
                           input logic [7:0] l, input logic d, input string nm);
        exp_t x;
        x.ep = e; x.cyc = c; x.st = s; x.leds = l; x.det = d; x.nm = nm;
        expQ.push_back(x);
    endtask

    task automatic checkOutput(input int k, input logic [2:0] s,
                               input logic [7:0] l, input logic d, input string nm);
        checkAt(ep, CLK_DIV * k, s, l, d, nm);
    endtask

    task automatic setIn(input logic c, input logic dg, input logic dm,
                         input logic im, input logic ab);
        in_combat = c; danger = dg; damaged = dm; immobilized = im; abort = ab;
    endtask

    // Stop at the negedge where the count reads c.
    task automatic waitCyc(input int c);
        int g = 0;
        while (cyc != c && g < TIMEOUT) begin
            @(negedge clk);
            g++;
        end
        if (cyc != c) begin
            vectors++;
            fails++;
            $display("[TB] FAIL waitCyc: count=%0d, required %0d", cyc, c);
        end
    endtask

    // Drive inputs so that they are sampled on tick k.
    task automatic applyStimulus(input int k, input logic c, input logic dg,
                                 input logic dm, input logic im, input logic ab);
        waitCyc(CLK_DIV * k - 1);
        setIn(c, dg, dm, im, ab);
    endtask

    task automatic waitDrain();
        int g = 0;
        while (expQ.size() > 0 && g < TIMEOUT) begin
            @(negedge clk);
            g++;
        end
        if (expQ.size() > 0) begin
            vectors++;
            fails++;
            $display("[TB] FAIL drain: %0d entries pending, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Called at a negedge. One-cycle reset; the state is checked right after.
    task automatic doReset();
        checkAt(ep + 1, 0, IDLE, 8'h00, 1'b0, "reset state");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic startScenario();
        waitDrain();
        @(negedge clk);
        doReset();
    endtask

    initial begin
        reset = 1'b0;
        setIn(0, 0, 0, 0, 0);
        barTab[0] = 8'h03; barTab[1] = 8'h07; barTab[2] = 8'h0F; barTab[3] = 8'h1F;
        barTab[4] = 8'h3F; barTab[5] = 8'h7F; barTab[6] = 8'hFF;

        // Full sequence, then terminal DETONATE ignores inputs.
        $display("[TB] full sequence");
        startScenario();
        setIn(1, 1, 1, 0, 0);
        checkAt(ep, 3, IDLE, 8'h00, 1'b0, "A no early tick");
        checkOutput(1, ARMED, 8'h00, 1'b0, "A armed");
        checkOutput(3, ARMED, 8'h00, 1'b0, "A still armed");
        checkOutput(4, CDOWN, 8'h01, 1'b0, "A countdown start");
        checkOutput(5, CDOWN, 8'h01, 1'b0, "A bar hold");
        for (int i = 0; i < 7; i++)
            checkOutput(6 + 2 * i, CDOWN, barTab[i], 1'b0, "A bar step");
        checkOutput(19, CDOWN, 8'hFF, 1'b0, "A bar full");
        checkOutput(20, FINAL, 8'h00, 1'b0, "A final entry");
        checkOutput(21, FINAL, 8'hFF, 1'b0, "A blink 21");
        checkOutput(22, FINAL, 8'h00, 1'b0, "A blink 22");
        checkOutput(23, FINAL, 8'hFF, 1'b0, "A blink 23");
        checkOutput(24, DET, 8'hFF, 1'b1, "A detonate");
        checkAt(ep, 97, DET, 8'hFF, 1'b1, "A hold between ticks");
        checkOutput(25, DET, 8'hFF, 1'b1, "A sticky abort");
        checkOutput(28, DET, 8'hFF, 1'b1, "A sticky abort 2");
        checkOutput(30, DET, 8'hFF, 1'b1, "A sticky rethreat");
        applyStimulus(25, 0, 0, 0, 0, 1);
        applyStimulus(29, 1, 1, 1, 0, 0);

        // Threat drop while arming; re-arm restarts the arm timer.
        $display("[TB] threat drop while arming");
        startScenario();
        setIn(1, 1, 1, 0, 0);
        checkOutput(1, ARMED, 8'h00, 1'b0, "B armed");
        checkOutput(2, ARMED, 8'h00, 1'b0, "B armed 2");
        checkOutput(3, IDLE, 8'h00, 1'b0, "B threat drop");
        checkOutput(4, IDLE, 8'h00, 1'b0, "B stays idle");
        checkOutput(5, ARMED, 8'h00, 1'b0, "B rearm");
        checkOutput(7, ARMED, 8'h00, 1'b0, "B arm timer restarted");
        checkOutput(8, CDOWN, 8'h01, 1'b0, "B countdown");
        applyStimulus(3, 1, 0, 1, 0, 0);
        applyStimulus(5, 1, 1, 1, 0, 0);

        // A single input is not a threat; two others are.
        $display("[TB] single input");
        startScenario();
        setIn(1, 0, 0, 1, 0);
        checkOutput(1, IDLE, 8'h00, 1'b0, "C single 1");
        checkOutput(5, IDLE, 8'h00, 1'b0, "C single 5");
        checkOutput(10, IDLE, 8'h00, 1'b0, "C single 10");
        checkOutput(11, ARMED, 8'h00, 1'b0, "C damaged+immob");
        applyStimulus(11, 1, 0, 1, 1, 0);

        // Abort in COUNTDOWN, cooldown ignores abort, re-arm needs abort=0.
        $display("[TB] abort in countdown");
        startScenario();
        setIn(1, 1, 1, 0, 0);
        checkOutput(4, CDOWN, 8'h01, 1'b0, "D countdown");
        checkOutput(8, CDOWN, 8'h07, 1'b0, "D bar 07");
        checkOutput(9, ABRT, 8'h00, 1'b0, "D aborted");
        checkOutput(13, ABRT, 8'h00, 1'b0, "D cooldown");
        checkOutput(14, IDLE, 8'h00, 1'b0, "D cooldown over");
        checkOutput(16, IDLE, 8'h00, 1'b0, "D no rearm with abort");
        checkOutput(17, ARMED, 8'h00, 1'b0, "D rearm");
        applyStimulus(9, 1, 1, 1, 0, 1);
        applyStimulus(17, 1, 1, 1, 0, 0);

        // Combat loss in FINAL.
        $display("[TB] combat loss in final");
        startScenario();
        setIn(1, 1, 1, 0, 0);
        checkOutput(21, FINAL, 8'hFF, 1'b0, "E blink on");
        checkOutput(22, ABRT, 8'h00, 1'b0, "E combat loss");
        checkOutput(26, ABRT, 8'h00, 1'b0, "E cooldown");
        checkOutput(27, IDLE, 8'h00, 1'b0, "E idle");
        applyStimulus(22, 0, 1, 1, 0, 0);

        // Threat loss in COUNTDOWN is ignored.
        $display("[TB] threat loss in countdown");
        startScenario();
        setIn(1, 1, 1, 0, 0);
        checkOutput(10, CDOWN, 8'h0F, 1'b0, "F bar 0F");
        checkOutput(12, CDOWN, 8'h1F, 1'b0, "F bar 1F");
        checkOutput(18, CDOWN, 8'hFF, 1'b0, "F bar FF");
        checkOutput(20, FINAL, 8'h00, 1'b0, "F final");
        checkOutput(24, DET, 8'hFF, 1'b1, "F detonate");
        applyStimulus(10, 1, 0, 0, 0, 0);

        // Mid-sequence reset at posedge 50; next tick at posedge 54.
        $display("[TB] mid-sequence reset");
        startScenario();
        setIn(1, 1, 1, 0, 0);
        checkOutput(12, CDOWN, 8'h1F, 1'b0, "G bar 1F");
        waitCyc(49);
        doReset();
        checkAt(ep, 3, IDLE, 8'h00, 1'b0, "G no early tick");
        checkOutput(1, ARMED, 8'h00, 1'b0, "G first tick");

        waitDrain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
